// File: rtl/count_sched_pkg.sv
// Shared types and constants for the count_sched scheduler and its arbiter.
package count_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/count_sched_rr_arb2.sv
// Two-input round-robin arbiter; combinational winner, registered last-grant pointer.
module rr_arb2 (
    input  logic       C,
    input  logic       R,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] win_c
);

    // last_q = index of the most recently granted requester; reset favours requester 0
    logic last_q;
    logic last_d;

    always_comb begin
        win_c  = 2'b00;
        last_d = last_q;
        unique case (req)
            2'b01:   win_c = 2'b01;
            2'b10:   win_c = 2'b10;
            2'b11:   win_c = last_q ? 2'b01 : 2'b10;
            default: win_c = 2'b00;
        endcase
        if (upd && (win_c != 2'b00)) begin
            last_d = win_c[1];
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler sharing one up/down counter between two requesters.
// Optional pause input EN is enabled by defining COUNT_SCHED_PAUSE_EN.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic [1:0]       REQ,
    input  logic             M0,
    input  logic             M1,
    input  logic [WIDTH-1:0] LIM0,
    input  logic [WIDTH-1:0] LIM1,
`ifdef COUNT_SCHED_PAUSE_EN
    input  logic             EN,
`endif
    output logic [1:0]       GNT,
    output logic [WIDTH-1:0] P,
    output logic             BUSY,
    output logic [1:0]       DONE
);

    state_e           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             busy_q, busy_d;
    logic [1:0]       done_q, done_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] lim_q, lim_d;

    logic [1:0]       win_c;
    logic             upd_c;
    logic             step_c;
    logic             dir_c;
    logic [WIDTH-1:0] lim_c;
    logic [WIDTH-1:0] term_c;

`ifdef COUNT_SCHED_PAUSE_EN
    assign step_c = EN;
`else
    assign step_c = 1'b1;
`endif

    assign upd_c  = (state_q == ST_IDLE) && (REQ != 2'b00);
    assign dir_c  = win_c[1] ? M1 : M0;
    assign lim_c  = win_c[1] ? LIM1 : LIM0;
    assign term_c = (dir_q == DIR_UP) ? lim_q : '0;

    rr_arb2 u_arb (
        .C     (C),
        .R     (R),
        .req   (REQ),
        .upd   (upd_c),
        .win_c (win_c)
    );

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        p_d     = p_q;
        busy_d  = busy_q;
        done_d  = 2'b00;
        dir_d   = dir_q;
        lim_d   = lim_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ != 2'b00) begin
                    state_d = ST_RUN;
                    gnt_d   = win_c;
                    busy_d  = 1'b1;
                    dir_d   = dir_c;
                    lim_d   = lim_c;
                    p_d     = (dir_c == DIR_UP) ? '0 : lim_c;
                end
            end
            ST_RUN: begin
                if ((REQ & gnt_q) == 2'b00) begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                    p_d     = '0;
                end else if (step_c) begin
                    if (p_q == term_c) begin
                        state_d = ST_DONE;
                        done_d  = gnt_q;
                    end else if (dir_q == DIR_UP) begin
                        p_d = p_q + WIDTH'(1);
                    end else begin
                        p_d = p_q - WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                p_d     = '0;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 2'b00;
            dir_q   <= DIR_UP;
            lim_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
            lim_q   <= lim_d;
        end
    end

    assign GNT  = gnt_q;
    assign P    = p_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_count_sched.sv
// Directed self-checking bench for count_sched (WIDTH = 4).
module tb_count_sched;

    logic       C = 1'b0;
    logic       R = 1'b1;
    logic [1:0] REQ = 2'b00;
    logic       M0 = 1'b0;
    logic       M1 = 1'b0;
    logic [3:0] LIM0 = 4'd0;
    logic [3:0] LIM1 = 4'd0;
`ifdef COUNT_SCHED_PAUSE_EN
    logic       EN = 1'b1;
`endif
    logic [1:0] GNT;
    logic [3:0] P;
    logic       BUSY;
    logic [1:0] DONE;

    int n_assert = 0;
    int n_fail   = 0;

    count_sched #(.WIDTH(4)) dut (
        .C    (C),
        .R    (R),
        .REQ  (REQ),
        .M0   (M0),
        .M1   (M1),
        .LIM0 (LIM0),
        .LIM1 (LIM1),
`ifdef COUNT_SCHED_PAUSE_EN
        .EN   (EN),
`endif
        .GNT  (GNT),
        .P    (P),
        .BUSY (BUSY),
        .DONE (DONE)
    );

    always #5 C = ~C;

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic [1:0] g, input logic [3:0] p,
                         input logic b, input logic [1:0] d);
        chk({tag, ".gnt"},  32'(GNT),  32'(g));
        chk({tag, ".p"},    32'(P),    32'(p));
        chk({tag, ".busy"}, 32'(BUSY), 32'(b));
        chk({tag, ".done"}, 32'(DONE), 32'(d));
    endtask

    initial begin
        int lim;
        logic [1:0] exp_g;

        // Reset state
        R = 1'b1;
        step();
        step();
        chk_o("reset", 2'b00, 4'd0, 1'b0, 2'b00);
        R = 1'b0;
        step();
        chk_o("idle_hold", 2'b00, 4'd0, 1'b0, 2'b00);

        // Single up job, LIM0 = 5; LIM0 change mid-job must be ignored
        M0 = 1'b0; LIM0 = 4'd5; REQ = 2'b01;
        step();
        chk_o("up_grant", 2'b01, 4'd0, 1'b1, 2'b00);
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) LIM0 = 4'd2;
            step();
            chk_o($sformatf("up_run%0d", i), 2'b01, 4'(i), 1'b1, 2'b00);
        end
        step();
        chk_o("up_done", 2'b01, 4'd5, 1'b1, 2'b01);
        REQ = 2'b00;
        step();
        chk_o("up_idle", 2'b00, 4'd5, 1'b0, 2'b00);

        // Down job with LIM1 = 0: one RUN cycle then DONE
        M1 = 1'b1; LIM1 = 4'd0; REQ = 2'b10;
        step();
        chk_o("dn0_grant", 2'b10, 4'd0, 1'b1, 2'b00);
        step();
        chk_o("dn0_done", 2'b10, 4'd0, 1'b1, 2'b10);
        REQ = 2'b00;
        step();
        chk_o("dn0_idle", 2'b00, 4'd0, 1'b0, 2'b00);

        // Down job from 3
        M1 = 1'b1; LIM1 = 4'd3; REQ = 2'b10;
        step();
        chk_o("dn3_grant", 2'b10, 4'd3, 1'b1, 2'b00);
        for (int i = 2; i >= 0; i--) begin
            step();
            chk($sformatf("dn3_p%0d", i), 32'(P), 32'(i));
        end
        step();
        chk_o("dn3_done", 2'b10, 4'd0, 1'b1, 2'b10);
        REQ = 2'b00;
        step();

        // Contention after reset: grants alternate 0,1,0,1
        R = 1'b1;
        step();
        R = 1'b0;
        M0 = 1'b0; LIM0 = 4'd1;
        M1 = 1'b0; LIM1 = 4'd2;
        REQ = 2'b11;
        for (int j = 0; j < 4; j++) begin
            exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
            lim   = (j % 2 == 0) ? 1 : 2;
            step();
            chk_o($sformatf("rr%0d_grant", j), exp_g, 4'd0, 1'b1, 2'b00);
            for (int k = 1; k <= lim; k++) begin
                step();
                chk($sformatf("rr%0d_p%0d", j, k), 32'(P), 32'(k));
            end
            step();
            chk_o($sformatf("rr%0d_done", j), exp_g, 4'(lim), 1'b1, exp_g);
            step();
            chk_o($sformatf("rr%0d_idle", j), 2'b00, 4'(lim), 1'b0, 2'b00);
        end
        REQ = 2'b00;
        step();

        // Abort: requester 0 up to 9, drop REQ[0] at P = 4; REQ[1] ignored meanwhile
        M0 = 1'b0; LIM0 = 4'd9; REQ = 2'b01;
        step();
        chk_o("ab_grant", 2'b01, 4'd0, 1'b1, 2'b00);
        REQ = 2'b11;
        for (int i = 1; i <= 4; i++) step();
        chk_o("ab_p4", 2'b01, 4'd4, 1'b1, 2'b00);
        REQ = 2'b00;
        step();
        chk_o("ab_idle", 2'b00, 4'd0, 1'b0, 2'b00);
        step();
        chk_o("ab_nodone", 2'b00, 4'd0, 1'b0, 2'b00);

        // Reset mid-RUN at P = 7; afterwards requester 0 wins contention
        M0 = 1'b0; LIM0 = 4'd15; REQ = 2'b01;
        step();
        for (int i = 1; i <= 7; i++) step();
        chk_o("rst_p7", 2'b01, 4'd7, 1'b1, 2'b00);
        R = 1'b1;
        step();
        chk_o("rst_mid", 2'b00, 4'd0, 1'b0, 2'b00);
        R = 1'b0;
        M0 = 1'b0; LIM0 = 4'd2; REQ = 2'b11;
        step();
        chk_o("rst_prio", 2'b01, 4'd0, 1'b1, 2'b00);
        REQ = 2'b00;
        step();
        chk_o("rst_abort", 2'b00, 4'd0, 1'b0, 2'b00);

`ifdef COUNT_SCHED_PAUSE_EN
        // Pause at P = 2 for 3 cycles; LIM0 change during the pause ignored
        M0 = 1'b0; LIM0 = 4'd4; REQ = 2'b01; EN = 1'b1;
        step();
        step();
        step();
        chk("pz_p2", 32'(P), 32'd2);
        EN = 1'b0; LIM0 = 4'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_o($sformatf("pz_hold%0d", i), 2'b01, 4'd2, 1'b1, 2'b00);
        end
        EN = 1'b1;
        step();
        chk("pz_p3", 32'(P), 32'd3);
        step();
        chk("pz_p4", 32'(P), 32'd4);
        step();
        chk_o("pz_done", 2'b01, 4'd4, 1'b1, 2'b01);
        REQ = 2'b00;
        step();
        chk_o("pz_idle", 2'b00, 4'd4, 1'b0, 2'b00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
